vx_execute_arb: RTL and testbench

//   Shares one execute-unit dispatch port among NUM_INPUTS issue requesters.

---
 rtl/vx_execute_arb_if.sv | 30 +++
 rtl/vx_execute_arb.sv | 155 +++++++++++++++
 tb/tb_vx_execute_arb.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/vx_execute_arb_if.sv
// Bundle of the requester-side and execute-unit-side signals of vx_execute_arb.
// The slave modport is the arbiter's view; master is the surrounding environment's view.
interface vx_execute_arb_if #(
    parameter int NUM_INPUTS = 4,
    parameter int DATA_WIDTH = 256,
    parameter int SEL_WIDTH  = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
);
    logic [NUM_INPUTS-1:0]            in_valid;
    logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data;
    logic [NUM_INPUTS-1:0]            in_sop;
    logic [NUM_INPUTS-1:0]            in_eop;
    logic [NUM_INPUTS-1:0]            in_ready;
    logic                             out_valid;
    logic [DATA_WIDTH-1:0]            out_data;
    logic                             out_sop;
    logic                             out_eop;
    logic [SEL_WIDTH-1:0]             out_sel;
    logic                             out_ready;
    logic                             locked;

    modport slave (
        input  in_valid, in_data, in_sop, in_eop, out_ready,
        output in_ready, out_valid, out_data, out_sop, out_eop, out_sel, locked
    );

    modport master (
        output in_valid, in_data, in_sop, in_eop, out_ready,
        input  in_ready, out_valid, out_data, out_sop, out_eop, out_sel, locked
    );
endinterface

// File: rtl/vx_execute_arb.sv
// Round-robin arbiter sharing one execute-unit dispatch port, locked across sop..eop packets.
// Define EXE_ARB_OUT_BUF_EN to register the output through a 2-entry skid buffer.
module vx_execute_arb #(
    parameter int NUM_INPUTS = 4,
    parameter int DATA_WIDTH = 256,
    parameter int SEL_WIDTH  = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic            clk,
    input  logic            reset,
    vx_execute_arb_if.slave arb
);
    logic [SEL_WIDTH-1:0]  rr_ptr_q, rr_ptr_d;
    logic                  lock_q, lock_d;
    logic [SEL_WIDTH-1:0]  lock_idx_q, lock_idx_d;
    logic [SEL_WIDTH-1:0]  grant;
    logic                  grant_valid;
    logic                  grant_sop;
    logic                  grant_eop;
    logic [DATA_WIDTH-1:0] grant_data;
    logic                  sink_ready;
    logic                  accept;
    int                    scan_idx;

    // Lowest-priority candidate is visited first so the one nearest rr_ptr wins last.
    always_comb begin
        grant    = rr_ptr_q;
        scan_idx = 0;
        if (reset) begin
            grant = '0;
        end else if (lock_q) begin
            grant = lock_idx_q;
        end else begin
            for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
                scan_idx = int'(rr_ptr_q) + k;
                if (scan_idx >= NUM_INPUTS) scan_idx = scan_idx - NUM_INPUTS;
                if (arb.in_valid[scan_idx]) grant = SEL_WIDTH'(scan_idx);
            end
        end
    end

    always_comb begin
        grant_valid = 1'b0;
        grant_sop   = 1'b0;
        grant_eop   = 1'b0;
        grant_data  = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (SEL_WIDTH'(i) == grant) begin
                grant_valid = arb.in_valid[i] && !reset;
                grant_sop   = arb.in_sop[i];
                grant_eop   = arb.in_eop[i];
                grant_data  = arb.in_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign accept = grant_valid && sink_ready;

    always_comb begin
        arb.in_ready = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (SEL_WIDTH'(i) == grant) arb.in_ready[i] = accept;
        end
    end

    // A non-eop beat pins the grant; eop releases it and moves priority past the owner.
    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        if (accept) begin
            if (grant_eop) begin
                lock_d   = 1'b0;
                rr_ptr_d = (int'(grant) == NUM_INPUTS - 1) ? '0 : grant + SEL_WIDTH'(1);
            end else begin
                lock_d     = 1'b1;
                lock_idx_d = grant;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q   <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
        end
    end

    assign arb.locked = lock_q;

`ifdef EXE_ARB_OUT_BUF_EN
    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  sop;
        logic                  eop;
        logic [SEL_WIDTH-1:0]  sel;
    } entry_t;

    entry_t     buf_q [2];
    entry_t     buf_d [2];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;
    logic       pop;

    // Acceptance depends only on occupancy, so out_ready never reaches in_ready.
    assign sink_ready = (count_q != 2'd2);
    assign pop        = arb.out_valid && arb.out_ready;

    always_comb begin
        buf_d    = buf_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (accept) begin
            buf_d[wr_ptr_q] = '{data: grant_data, sop: grant_sop, eop: grant_eop, sel: grant};
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) rd_ptr_d = ~rd_ptr_q;
        count_d = count_q + 2'(accept) - 2'(pop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_q[0] <= '0;
            buf_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            buf_q[0] <= buf_d[0];
            buf_q[1] <= buf_d[1];
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign arb.out_valid = (count_q != 2'd0);
    assign arb.out_data  = buf_q[rd_ptr_q].data;
    assign arb.out_sop   = buf_q[rd_ptr_q].sop;
    assign arb.out_eop   = buf_q[rd_ptr_q].eop;
    assign arb.out_sel   = buf_q[rd_ptr_q].sel;
`else
    assign sink_ready    = arb.out_ready;
    assign arb.out_valid = grant_valid;
    assign arb.out_data  = grant_data;
    assign arb.out_sop   = grant_sop;
    assign arb.out_eop   = grant_eop;
    assign arb.out_sel   = grant;
`endif
endmodule

// File: tb/tb_vx_execute_arb.sv
// Directed bench for vx_execute_arb (default unbuffered build): a cycle table for
// round-robin / lock behaviour plus hand-written reset, stall and mid-packet-reset sequences.
module tb_vx_execute_arb;
    localparam int NI = 4;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   handshakes;
    logic pending;

    always #5 clk = ~clk;

    vx_execute_arb_if #(.NUM_INPUTS(NI), .DATA_WIDTH(DW)) bus ();

    vx_execute_arb #(.NUM_INPUTS(NI), .DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .arb   (bus)
    );

    typedef struct {
        logic [3:0] v;
        logic [3:0] s;
        logic [3:0] e;
        logic       r;
        logic       ov;
        logic [1:0] sel;
        logic [3:0] rdy;
        logic       lk;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [DW-1:0] beatData(input int cyc, input int idx);
        return {8'(cyc), 8'(idx), 16'hC0DE};
    endfunction

    task automatic addVec(input logic [3:0] v, input logic [3:0] s, input logic [3:0] e,
                          input logic r, input logic ov, input logic [1:0] sel,
                          input logic [3:0] rdy, input logic lk);
        vec_t t;
        t.v = v; t.s = s; t.e = e; t.r = r;
        t.ov = ov; t.sel = sel; t.rdy = rdy; t.lk = lk;
        vecs.push_back(t);
    endtask

    task automatic applyStimulus(input logic [3:0] v, input logic [3:0] s, input logic [3:0] e,
                                 input logic r, input int cyc);
        bus.in_valid  = v;
        bus.in_sop    = s;
        bus.in_eop    = e;
        bus.out_ready = r;
        for (int i = 0; i < NI; i++) bus.in_data[i*DW +: DW] = beatData(cyc, i);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        reset = 1'b0;
        applyStimulus(4'b0, 4'b0, 4'b0, 1'b0, 0);
        #2 reset = 1'b1;
        #1;
        checkOutput("rst out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst out_sel",   32'(bus.out_sel),   32'd0);
        checkOutput("rst locked",    32'(bus.locked),    32'd0);
        checkOutput("rst in_ready",  32'(bus.in_ready),  32'd0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Idle after reset release, execute unit ready.
        for (int k = 0; k < 10; k++) begin
            applyStimulus(4'b0, 4'b0, 4'b0, 1'b1, k);
            #2;
            checkOutput($sformatf("idle%0d out_valid", k), 32'(bus.out_valid), 32'd0);
            checkOutput($sformatf("idle%0d locked", k),    32'(bus.locked),    32'd0);
            checkOutput($sformatf("idle%0d in_ready", k),  32'(bus.in_ready),  32'd0);
            @(posedge clk);
            #1;
        end

        //     valid    sop      eop      rdy  ov   sel   in_ready lk
        addVec(4'b1111, 4'b1111, 4'b1111, 1'b1, 1'b1, 2'd0, 4'b0001, 1'b0);
        addVec(4'b1111, 4'b1111, 4'b1111, 1'b1, 1'b1, 2'd1, 4'b0010, 1'b0);
        addVec(4'b1111, 4'b1111, 4'b1111, 1'b1, 1'b1, 2'd2, 4'b0100, 1'b0);
        addVec(4'b1111, 4'b1111, 4'b1111, 1'b1, 1'b1, 2'd3, 4'b1000, 1'b0);
        addVec(4'b1111, 4'b1111, 4'b1111, 1'b1, 1'b1, 2'd0, 4'b0001, 1'b0);
        addVec(4'b0010, 4'b0010, 4'b0010, 1'b1, 1'b1, 2'd1, 4'b0010, 1'b0);
        addVec(4'b0011, 4'b0011, 4'b0010, 1'b1, 1'b1, 2'd0, 4'b0001, 1'b0);
        addVec(4'b0011, 4'b0010, 4'b0010, 1'b1, 1'b1, 2'd0, 4'b0001, 1'b1);
        addVec(4'b0011, 4'b0010, 4'b0010, 1'b1, 1'b1, 2'd0, 4'b0001, 1'b1);
        addVec(4'b0011, 4'b0010, 4'b0011, 1'b1, 1'b1, 2'd0, 4'b0001, 1'b1);
        addVec(4'b0010, 4'b0010, 4'b0010, 1'b1, 1'b1, 2'd1, 4'b0010, 1'b0);
        addVec(4'b0101, 4'b0101, 4'b0001, 1'b1, 1'b1, 2'd2, 4'b0100, 1'b0);
        addVec(4'b0001, 4'b0001, 4'b0001, 1'b1, 1'b0, 2'd2, 4'b0000, 1'b1);
        addVec(4'b0001, 4'b0001, 4'b0001, 1'b1, 1'b0, 2'd2, 4'b0000, 1'b1);
        addVec(4'b0001, 4'b0001, 4'b0001, 1'b1, 1'b0, 2'd2, 4'b0000, 1'b1);
        addVec(4'b0101, 4'b0001, 4'b0001, 1'b1, 1'b1, 2'd2, 4'b0100, 1'b1);
        addVec(4'b0101, 4'b0001, 4'b0101, 1'b1, 1'b1, 2'd2, 4'b0100, 1'b1);
        addVec(4'b0001, 4'b0001, 4'b0001, 1'b1, 1'b1, 2'd0, 4'b0001, 1'b0);
        addVec(4'b0010, 4'b0000, 4'b0010, 1'b1, 1'b1, 2'd1, 4'b0010, 1'b0);
        addVec(4'b1000, 4'b1000, 4'b0000, 1'b0, 1'b1, 2'd3, 4'b0000, 1'b0);
        addVec(4'b1000, 4'b1000, 4'b0000, 1'b1, 1'b1, 2'd3, 4'b1000, 1'b0);
        addVec(4'b1001, 4'b0001, 4'b1001, 1'b1, 1'b1, 2'd3, 4'b1000, 1'b1);
        addVec(4'b1001, 4'b1001, 4'b1001, 1'b1, 1'b1, 2'd0, 4'b0001, 1'b0);
        addVec(4'b1000, 4'b1000, 4'b1000, 1'b1, 1'b1, 2'd3, 4'b1000, 1'b0);

        for (int c = 0; c < vecs.size(); c++) begin
            applyStimulus(vecs[c].v, vecs[c].s, vecs[c].e, vecs[c].r, c);
            #2;
            checkOutput($sformatf("v%0d out_valid", c), 32'(bus.out_valid), 32'(vecs[c].ov));
            checkOutput($sformatf("v%0d in_ready", c),  32'(bus.in_ready),  32'(vecs[c].rdy));
            checkOutput($sformatf("v%0d locked", c),    32'(bus.locked),    32'(vecs[c].lk));
            if (vecs[c].ov) begin
                checkOutput($sformatf("v%0d out_sel", c),  32'(bus.out_sel),  32'(vecs[c].sel));
                checkOutput($sformatf("v%0d out_data", c), 32'(bus.out_data),
                            32'(beatData(c, int'(vecs[c].sel))));
                checkOutput($sformatf("v%0d out_eop", c),  32'(bus.out_eop),
                            32'(vecs[c].e[vecs[c].sel]));
            end
            @(posedge clk);
            #1;
        end

        // Stall: in1 holds 0xA5 through five not-ready cycles, then exactly one delivery.
        handshakes = 0;
        pending    = 1'b1;
        for (int k = 0; k < 8; k++) begin
            applyStimulus(pending ? 4'b0010 : 4'b0000, 4'b0010, 4'b0010, (k >= 5), 0);
            bus.in_data[1*DW +: DW] = 32'hA5;
            #2;
            if (k < 5) begin
                checkOutput($sformatf("stall%0d out_valid", k), 32'(bus.out_valid),   32'd1);
                checkOutput($sformatf("stall%0d out_data", k),  32'(bus.out_data),    32'hA5);
                checkOutput($sformatf("stall%0d in_ready1", k), 32'(bus.in_ready[1]), 32'd0);
            end
            if (bus.out_valid && bus.out_ready) handshakes++;
            if (bus.in_valid[1] && bus.in_ready[1]) pending = 1'b0;
            @(posedge clk);
            #1;
        end
        checkOutput("stall deliveries", 32'(handshakes), 32'd1);

        // Move rr_ptr to 3, lock on in3, then reset mid-packet.
        applyStimulus(4'b0100, 4'b0100, 4'b0100, 1'b1, 100);
        #2 checkOutput("pre-rst in2 sel", 32'(bus.out_sel), 32'd2);
        @(posedge clk);
        #1 applyStimulus(4'b1000, 4'b1000, 4'b0000, 1'b1, 101);
        #2 checkOutput("pre-rst in3 sel", 32'(bus.out_sel), 32'd3);
        @(posedge clk);
        #1 applyStimulus(4'b1001, 4'b0001, 4'b0001, 1'b1, 102);
        #2;
        checkOutput("pre-rst locked", 32'(bus.locked),  32'd1);
        checkOutput("pre-rst sel",    32'(bus.out_sel), 32'd3);
        #2 reset = 1'b1;
        #1;
        checkOutput("midrst out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("midrst locked",    32'(bus.locked),    32'd0);
        checkOutput("midrst in_ready",  32'(bus.in_ready),  32'd0);
        checkOutput("midrst out_sel",   32'(bus.out_sel),   32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        applyStimulus(4'b1001, 4'b1001, 4'b1001, 1'b1, 103);
        #2;
        checkOutput("postrst out_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("postrst out_sel",   32'(bus.out_sel),   32'd0);
        checkOutput("postrst locked",    32'(bus.locked),    32'd0);
        @(posedge clk);
        #1 applyStimulus(4'b0, 4'b0, 4'b0, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
